store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 106 ++++++++++
 tb/tb_store_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and word-addressed data memory.
// Optional feature: define STORE_BUF_COALESCE_EN to merge stores to buffered addresses.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_stall,
  output logic          sb_empty,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  logic          r_rvalid, r_hit;
  logic [DW-1:0] r_hit_data;

  logic          w_full, w_match, w_drain, w_store, w_push, w_overwrite;
  logic [PW-1:0] w_match_idx;

  // Walk oldest to youngest so the last hit seen is the youngest match.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_match     = 1'b0;
    w_match_idx = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < r_count) && (r_addr[r_head + PW'(k)] == cpu_addr)) begin
        w_match     = 1'b1;
        w_match_idx = r_head + PW'(k);
      end
    end
  end

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_drain = ~cpu_read & (r_count != '0);
  assign w_store = cpu_write & ~cpu_read;

`ifdef STORE_BUF_COALESCE_EN
  // A match on the head that is leaving this cycle must allocate instead.
  assign w_overwrite = w_store & w_match & ~(w_drain && (w_match_idx == r_head));
  assign cpu_stall   = w_store & w_full & ~w_match;
  assign w_push      = w_store & ~w_overwrite & ~cpu_stall;
`else
  assign w_overwrite = 1'b0;
  assign cpu_stall   = w_store & w_full;
  assign w_push      = w_store & ~w_full;
`endif

  assign sb_empty   = (r_count == '0);
  assign mem_write  = w_drain;
  assign mem_read   = cpu_read & ~w_match;
  assign mem_addr   = mem_read ? cpu_addr : r_addr[r_head];
  assign mem_wdata  = r_data[r_head];
  assign cpu_rvalid = r_rvalid;
  assign cpu_rdata  = r_rvalid ? (r_hit ? r_hit_data : mem_rdata) : '0;

  // NOTE: entry storage is deliberately not reset; validity comes from r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= cpu_addr;
      r_data[r_tail] <= cpu_wdata;
    end else if (w_overwrite) begin
      r_data[w_match_idx] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rvalid   <= 1'b0;
      r_hit      <= 1'b0;
      r_hit_data <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rvalid <= cpu_read;
      r_hit    <= cpu_read & w_match;
      if (cpu_read && w_match) r_hit_data <= r_data[w_match_idx];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: queue-based reference model, decoupled output monitor.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_read = 1'b0, cpu_write = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic          cpu_rvalid, cpu_stall, sb_empty, mem_read, mem_write;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall), .sb_empty(sb_empty),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input int a);
    return (a == 9) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(a));
  endfunction

  // Data memory with registered read; unwritten words hold init_val.
  logic [DW-1:0] phys_mem [64];
  bit            phys_wr  [64] = '{default: 1'b0};
  always @(posedge clk) begin
    if (mem_write) begin
      phys_mem[mem_addr[5:0]] <= mem_wdata;
      phys_wr[mem_addr[5:0]]  <= 1'b1;
    end
    if (mem_read)
      mem_rdata <= phys_wr[mem_addr[5:0]] ? phys_mem[mem_addr[5:0]] : init_val(int'(mem_addr[5:0]));
  end

  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  typedef struct { logic [31:0] data; int due; } ld_t;

  st_t           sbq[$];
  st_t           wr_q[$];
  ld_t           load_q[$];
  logic [31:0]   ref_mem [64];
  int            cyc = 0;
  int            n_checks = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: pops expected load data and memory writes whenever the DUT presents them.
  ld_t mon_ld;
  st_t mon_wr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_rvalid) begin
        if (load_q.size() == 0) check("rvalid_unexpected", cpu_rvalid, 0);
        else begin
          mon_ld = load_q.pop_front();
          check("load_data", cpu_rdata, mon_ld.data);
        end
      end else if (load_q.size() > 0 && load_q[0].due <= cyc) begin
        void'(load_q.pop_front());
        check("rvalid_missing", cpu_rvalid, 1);
      end
      if (mem_write) begin
        if (wr_q.size() == 0) check("mem_write_unexpected", mem_write, 0);
        else begin
          mon_wr = wr_q.pop_front();
          check("drain_addr", mem_addr, mon_wr.addr);
          check("drain_data", mem_wdata, mon_wr.data);
        end
      end else if (wr_q.size() > 0) begin
        void'(wr_q.pop_front());
        check("mem_write_missing", mem_write, 1);
      end
    end
  end

  function automatic int youngest(input logic [31:0] a);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].addr == a) return i;
    return -1;
  endfunction

  // Drive one cycle at posedge+1, update the model, check combinational outputs at negedge.
  task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int  j;
    bit  drain, exp_mrd, exp_stall, exp_empty;
    st_t h, n;
    ld_t l;
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
    exp_mrd = 1'b0; exp_stall = 1'b0;
    exp_empty = (sbq.size() == 0);
    j     = youngest(a);
    drain = !rd && sbq.size() > 0;
    if (rd) begin
      l.due = cyc + 1;
      if (j >= 0) l.data = sbq[j].data;
      else begin
        exp_mrd = 1'b1;
        l.data  = ref_mem[a[5:0]];
      end
      load_q.push_back(l);
    end else begin
      if (drain) begin
        h = sbq[0];
        wr_q.push_back(h);
      end
      n.addr = a; n.data = d;
      if (wr) begin
`ifdef STORE_BUF_COALESCE_EN
        if (j > 0) sbq[j].data = d;
        else if (sbq.size() < DEPTH || j == 0) sbq.push_back(n);
        else exp_stall = 1'b1;
`else
        if (sbq.size() < DEPTH) sbq.push_back(n);
        else exp_stall = 1'b1;
`endif
      end
      if (drain) begin
        void'(sbq.pop_front());
        ref_mem[h.addr[5:0]] = h.data;
      end
    end
    @(negedge clk);
    check("cpu_stall", cpu_stall, exp_stall);
    check("sb_empty", sb_empty, exp_empty);
    check("mem_read", mem_read, exp_mrd);
    if (exp_mrd) check("mem_addr_load", mem_addr, a);
    check("rw_exclusive", mem_read & mem_write, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset asserted between edges; discards model buffer and in-flight responses.
  task automatic do_reset(input int cycles);
    cpu_read = 1'b0; cpu_write = 1'b0;
    rst_n = 1'b0;
    sbq.delete(); wr_q.delete(); load_q.delete();
    repeat (cycles) begin
      @(negedge clk);
      check("rst_sb_empty", sb_empty, 1);
      check("rst_rvalid", cpu_rvalid, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_read", mem_read, 0);
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    do_reset(2);

    step(1'b1, 1'b0, 32'd9, '0);
    step(1'b0, 1'b1, 32'd5, 32'hAAAA_0001);
    step(1'b0, 1'b1, 32'd5, 32'hBBBB_0002);
    step(1'b1, 1'b0, 32'd5, '0);
    idle(2);

    for (int a = 1; a <= 5; a++) step(1'b0, 1'b1, 32'(a), 32'h5100_0000 | 32'(a));
    idle(2);

    for (int a = 0; a < 3; a++) step(1'b0, 1'b1, 32'(10 + a), $urandom);
    for (int a = 0; a < 4; a++) step(1'b1, 1'b0, 32'(40 + a), '0);
    idle(2);
    for (int a = 0; a < 6; a++) step(1'b0, 1'b1, 32'(30 + a), $urandom);
    idle(2);
    for (int a = 0; a < 6; a++) step(1'b1, 1'b0, 32'(30 + a), '0);

    step(1'b0, 1'b1, 32'd20, 32'hD0D0_0020);
    step(1'b0, 1'b1, 32'd21, 32'hD0D0_0021);
    do_reset(1);
    idle(1);
    step(1'b1, 1'b0, 32'd20, '0);
    step(1'b1, 1'b0, 32'd21, '0);
    step(1'b1, 1'b1, 32'd22, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'd22, '0);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)       step(1'b1, 1'b0, 32'($urandom_range(0, 15)), '0);
      else if (r < 8)  step(1'b0, 1'b1, 32'($urandom_range(0, 15)), $urandom);
      else if (r == 8) step(1'b1, 1'b1, 32'($urandom_range(0, 15)), $urandom);
      else             idle(1);
    end
    idle(2);
    for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 32'(a), '0);
    idle(2);
    check("load_q_drained", 64'(load_q.size()), 0);
    check("wr_q_drained", 64'(wr_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
